al_accel_wback_arbiter: RTL
===========================

Name: al_accel_wback_arbiter

Overview:
- Shares the single output-memory write port among the NUM_LANE quant/activation lanes that feed write-back.
- Round-robin arbitration over lane requests.
- Generates per-lane write addresses, counts words per lane up to output2D_size, and signals completion of one layer's write-back.
- Sits between the quant/act lanes and the output SRAM write port, alongside the write-back controller that starts it.

Parameters:
- NUM_LANE, 3, number of quant/act lanes (requesters); must be ≥1.
- DATA_W, 32, write data width.
- ADDR_W, 32, byte address width.

Ports:
- clk  input  1  clock
- resetn  input  1  asynchronous active-low reset
- enb  input  1  global enable; 0 freezes arbitration and counters
- start  input  1  one-cycle pulse; latches config, begins a layer; ignored unless IDLE
- cfg_base_addr  input  ADDR_W  byte address of lane 0, word 0
- cfg_lane_stride  input  ADDR_W  byte offset between consecutive lanes' regions
- output2D_size  input  16  words each lane writes this layer
- lane_valid  input  NUM_LANE  lane i has a word ready
- lane_data  input  NUM_LANE*DATA_W  lane i data at bits [i*DATA_W +: DATA_W]
- lane_ready  output  NUM_LANE  one-hot pulse; lane i's word consumed this cycle
- mem_we  output  1  write request, held until accepted
- mem_addr  output  ADDR_W  write byte address
- mem_wdata  output  DATA_W  write data
- mem_ready  input  1  memory accepts the write when mem_we and mem_ready are both 1
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse at layer completion

Behaviour:
- Reset values: all outputs 0; state IDLE; RR pointer = lane 0; all lane counters 0.
- States:
  - IDLE. On start & enb: latch cfg_*, output2D_size, clear counters, go to RUN.
  - RUN. Arbitrate. When every lane count equals the latched size and the output slot is empty, go to DONE.
  - DONE. done=1 for exactly one cycle, then go to IDLE.
- output2D_size=0 at start: RUN→DONE on the next cycle with no writes; done pulses 2 cycles after start.
- Output slot: a single register (mem_we/mem_addr/mem_wdata).
  - Slot is free when mem_we=0, or when mem_we & mem_ready in the current cycle. This gives full throughput of 1 write per cycle.
- Grant: when in RUN, enb=1 and the slot is free:
  - Eligible lanes have lane_valid=1 and count < size.
  - Pick the first eligible lane at or after the RR pointer, wrapping modulo NUM_LANE.
  - For the granted lane g:
    - lane_ready[g]=1 combinationally that cycle.
    - Next cycle: mem_we=1, mem_wdata=lane_data[g], mem_addr = base + g*stride + count[g]*4.
    - count[g]++.
    - RR pointer ← (g+1) mod NUM_LANE.
  - With no eligible lane: no grant, pointer unchanged.
  - Latency: lane_valid to mem_we is 1 cycle.
- Write hold: mem_we, mem_addr and mem_wdata stay stable until mem_ready. mem_we drops the cycle after acceptance unless a new grant reloads the slot.
- Address arithmetic:
  - Modulo 2^ADDR_W; wrap is not flagged.
  - g*stride is computed ADDR_W wide.
  - count is 16 bits, zero-extended and shifted left by 2.
- Finished lanes: a lane whose count equals size is never granted; its lane_valid is ignored and lane_ready stays 0.
- enb=0:
  - No new grant, and lane_ready=0.
  - Counters, pointer and state hold.
  - A pending mem_we remains asserted and may still be accepted by mem_ready.
  - DONE is not entered while enb=0.
- start while in RUN or DONE: ignored.
- Config inputs may change after start without effect, since they are latched.
- Asynchronous reset mid-layer returns to the reset values immediately, dropping mem_we. No done pulse.

Decomposition:
- Shared package:
  - state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - layer-type constants (CONV=4'd0, DENSE=4'd1, POOL=4'd2) for the write-back controller family.
- Sub-module al_accel_rr_arbiter:
  - NUM_LANE-wide request vector plus pointer in; one-hot grant and grant index out.
  - Purely combinational; the pointer register stays in the parent.

Test Plan:
- Basic RR:
  - Stimulus: NUM_LANE=3, base=1000, stride=400, size=2, all lanes valid continuously, mem_ready=1.
  - Required: writes in lane order 0,1,2,0,1,2 at addresses 1000, 1400, 1800, 1004, 1404, 1804, one per cycle.
  - done pulses 1 cycle after the last accept; busy drops with it.
- Backpressure:
  - Stimulus: mem_ready=0 for 5 cycles after the first write.
  - Required: mem_we, mem_addr and mem_wdata stay constant, and no lane_ready during those 5 cycles.
  - Resume gives back-to-back writes.
- Sparse/finished lanes:
  - Stimulus: only lane 2 valid, size=3.
  - Required: 3 writes at base+2*stride+{0,4,8}. Further lane 2 valid gets no lane_ready, and done never fires.
  - Then raise lanes 0 and 1 until complete; done fires.
- Zero size:
  - Stimulus: start with output2D_size=0.
  - Required: no mem_we; done pulses exactly 2 cycles after start.
- enb and start gating:
  - Stimulus: drop enb mid-layer for 4 cycles, and pulse start during RUN.
  - Required: no grants while enb is low, counters preserved, start ignored, total write count unchanged.
- Reset mid-operation:
  - Stimulus: assert resetn=0 asynchronously while mem_we=1.
  - Required: mem_we, busy and done go 0 immediately.
  - After release, a new start writes from word 0 again.

Source files
------------

// File: rtl/al_accel_wback_arbiter_pkg.sv
// Shared types for the write-back arbiter family: FSM encoding and layer-type codes.
// No logic here; it is imported by the arbiter and by the write-back controller.
package al_accel_wback_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [3:0] LAYER_CONV  = 4'd0;
   localparam logic [3:0] LAYER_DENSE = 4'd1;
   localparam logic [3:0] LAYER_POOL  = 4'd2;

endpackage

// File: rtl/al_accel_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping; zero latency.
// Has no state and no backpressure of its own; the caller masks req when it cannot accept.
module al_accel_rr_arbiter
   import al_accel_wback_arbiter_pkg::*;
#(
   parameter int NUM_LANE = 3,
   parameter int IDX_W    = (NUM_LANE > 1) ? $clog2(NUM_LANE) : 1
) (
   input  logic [NUM_LANE-1:0] req,
   input  logic [IDX_W-1:0]    ptr,
   output logic [NUM_LANE-1:0] gnt,
   output logic [IDX_W-1:0]    gnt_idx,
   output logic                gnt_vld
);

   int idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      idx     = 0;
      for (int off = 0; off < NUM_LANE; off++) begin
         idx = (int'(ptr) + off) % NUM_LANE;
         if (!gnt_vld && req[idx]) begin
            gnt_vld  = 1'b1;
            gnt[idx] = 1'b1;
            gnt_idx  = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/al_accel_wback_arbiter.sv
// Round-robin share of the output SRAM write port among quant/act lanes; lane_valid to mem_we is 1 cycle.
// A single output slot holds mem_* until mem_ready; a new grant is made only while the slot is free.
module al_accel_wback_arbiter
   import al_accel_wback_arbiter_pkg::*;
#(
   parameter int NUM_LANE = 3,
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 32
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       enb,
   input  logic                       start,
   input  logic [ADDR_W-1:0]          cfg_base_addr,
   input  logic [ADDR_W-1:0]          cfg_lane_stride,
   input  logic [15:0]                output2D_size,
   input  logic [NUM_LANE-1:0]        lane_valid,
   input  logic [NUM_LANE*DATA_W-1:0] lane_data,
   output logic [NUM_LANE-1:0]        lane_ready,
   output logic                       mem_we,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic [DATA_W-1:0]          mem_wdata,
   input  logic                       mem_ready,
   output logic                       busy,
   output logic                       done
);

   localparam int IDX_W = (NUM_LANE > 1) ? $clog2(NUM_LANE) : 1;

   state_t              state;
   logic [IDX_W-1:0]    rr_ptr;
   logic [15:0]         cnt [NUM_LANE];
   logic [ADDR_W-1:0]   base_q;
   logic [ADDR_W-1:0]   stride_q;
   logic [15:0]         size_q;

   logic [NUM_LANE-1:0] elig;
   logic [NUM_LANE-1:0] req;
   logic [NUM_LANE-1:0] gnt;
   logic [IDX_W-1:0]    gnt_idx;
   logic                gnt_vld;
   logic                slot_free;
   logic                all_fin;
   logic [ADDR_W-1:0]   wr_addr;
   logic [DATA_W-1:0]   wr_data;

   always_comb begin
      elig    = '0;
      all_fin = 1'b1;
      for (int i = 0; i < NUM_LANE; i++) begin
         elig[i] = lane_valid[i] && (cnt[i] < size_q);
         if (cnt[i] != size_q) all_fin = 1'b0;
      end
      // Slot counts as free when its current word is being accepted this cycle.
      slot_free = !mem_we || mem_ready;
      req       = ((state == ST_RUN) && enb && slot_free) ? elig : '0;
      wr_addr   = base_q + ADDR_W'(gnt_idx) * stride_q + (ADDR_W'(cnt[gnt_idx]) << 2);
      wr_data   = lane_data[int'(gnt_idx)*DATA_W +: DATA_W];
   end

   al_accel_rr_arbiter #(
      .NUM_LANE (NUM_LANE),
      .IDX_W    (IDX_W)
   ) u_rr (
      .req     (req),
      .ptr     (rr_ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

   assign lane_ready = gnt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= ST_IDLE;
         rr_ptr    <= '0;
         base_q    <= '0;
         stride_q  <= '0;
         size_q    <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         for (int i = 0; i < NUM_LANE; i++) cnt[i] <= '0;
      end else begin
         if (gnt_vld) begin
            mem_we       <= 1'b1;
            mem_addr     <= wr_addr;
            mem_wdata    <= wr_data;
            cnt[gnt_idx] <= cnt[gnt_idx] + 16'd1;
            rr_ptr       <= (gnt_idx == IDX_W'(NUM_LANE - 1)) ? '0 : gnt_idx + 1'b1;
         end else if (mem_we && mem_ready) begin
            mem_we <= 1'b0;
         end
         done <= 1'b0;
         case (state)
            ST_IDLE: if (start && enb) begin
               base_q   <= cfg_base_addr;
               stride_q <= cfg_lane_stride;
               size_q   <= output2D_size;
               for (int i = 0; i < NUM_LANE; i++) cnt[i] <= '0;
               state    <= ST_RUN;
               busy     <= 1'b1;
            end
            ST_RUN: if (enb && all_fin && slot_free) begin
               state <= ST_DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
